// File: rtl/scr1_tapc_sync_os.sv
// scr1_tapc_sync_os: TCK-to-SysCLK oversampling synchronizer with idle detect (ratio checker under SCR1_TAPC_SYNC_RATIO_CHK_EN)
module scr1_tapc_sync_os #(
  parameter int SYNC_STAGES = 2,
  parameter int RISE_W      = 3,
  parameter int FALL_W      = 1,
  parameter int LEVEL_W     = 8,
  parameter int IDLE_CNT_W  = 8,
  parameter int MIN_RATIO   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tck_divpos_i,
  input  logic               tck_divneg_i,
  input  logic [RISE_W-1:0]  rise_data_i,
  input  logic [FALL_W-1:0]  fall_data_i,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic               err_clr_i,
  output logic               tck_rise_o,
  output logic               tck_fall_o,
  output logic [RISE_W-1:0]  rise_data_o,
  output logic [FALL_W-1:0]  fall_data_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               tck_idle_o,
  output logic               ratio_err_o
);
  localparam int S = SYNC_STAGES;
  logic [S+1:0]               pos_sync, neg_sync;
  logic [S-1:0][RISE_W-1:0]   rd_sync;
  logic [IDLE_CNT_W-1:0]      idle_cnt;
  logic                       rise_load, rise_rst, fall_load, fall_rst;
  assign rise_load = pos_sync[S] ^ pos_sync[S-1];
  assign rise_rst  = pos_sync[S+1] ^ pos_sync[S];
  assign fall_load = neg_sync[S] ^ neg_sync[S-1];
  assign fall_rst  = neg_sync[S+1] ^ neg_sync[S];
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_sync    <= '0;
      neg_sync    <= '0;
      rd_sync     <= '0;
      idle_cnt    <= '0;
      tck_rise_o  <= 1'b0;
      tck_fall_o  <= 1'b0;
      rise_data_o <= '0;
      fall_data_o <= '0;
      level_o     <= '0;
      tck_idle_o  <= 1'b0;
    end else begin
      pos_sync    <= {pos_sync[S:0], tck_divpos_i};
      neg_sync    <= {neg_sync[S:0], tck_divneg_i};
      rd_sync     <= {rd_sync[S-2:0], rise_data_i};
      tck_rise_o  <= rise_load ? 1'b1 : rise_rst ? 1'b0 : tck_rise_o;
      rise_data_o <= rise_load ? rd_sync[S-1] : rise_rst ? '0 : rise_data_o;
      tck_fall_o  <= fall_load;
      fall_data_o <= fall_load ? fall_data_i : fall_rst ? '0 : fall_data_o;
      level_o     <= rise_load ? level_i : level_o;
      idle_cnt    <= rise_load ? '0 : (&idle_cnt) ? idle_cnt : idle_cnt + 1'b1;
      tck_idle_o  <= &idle_cnt;
    end
  end
`ifdef SCR1_TAPC_SYNC_RATIO_CHK_EN
  logic seen_edge;
  // idle_cnt holds (clk cycles since previous rise) - 1 at the moment of a new rise_load
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_edge   <= 1'b0;
      ratio_err_o <= 1'b0;
    end else begin
      seen_edge   <= seen_edge | rise_load;
      ratio_err_o <= (rise_load && seen_edge && idle_cnt < IDLE_CNT_W'(MIN_RATIO-1)) ? 1'b1 :
                     err_clr_i ? 1'b0 : ratio_err_o;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign ratio_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_scr1_tapc_sync_os.sv
// tb_scr1_tapc_sync_os: directed + randomized bench against an edge-schedule reference model
module tb_scr1_tapc_sync_os;
  localparam int S = 2, RW = 3, FW = 1, LW = 8, IW = 4, MR = 4, N = 2048;
  localparam int SAT = (1 << IW) - 1;
  logic clk = 0, rst = 1, pos = 0, neg = 0, clr = 0;
  logic [RW-1:0] rd = '0;
  logic [FW-1:0] fd = '0;
  logic [LW-1:0] lv = '0;
  logic tck_rise_o, tck_fall_o, tck_idle_o, ratio_err_o;
  logic [RW-1:0] rise_data_o;
  logic [FW-1:0] fall_data_o;
  logic [LW-1:0] level_o;
  always #5 clk = ~clk;
  scr1_tapc_sync_os #(.SYNC_STAGES(S), .RISE_W(RW), .FALL_W(FW), .LEVEL_W(LW),
                      .IDLE_CNT_W(IW), .MIN_RATIO(MR)) dut (
    .clk(clk), .rst(rst), .tck_divpos_i(pos), .tck_divneg_i(neg),
    .rise_data_i(rd), .fall_data_i(fd), .level_i(lv), .err_clr_i(clr),
    .tck_rise_o(tck_rise_o), .tck_fall_o(tck_fall_o), .rise_data_o(rise_data_o),
    .fall_data_o(fall_data_o), .level_o(level_o), .tck_idle_o(tck_idle_o),
    .ratio_err_o(ratio_err_o));
  int passed = 0, total = 0, fails = 0, e = 0, since = 0;
  bit sr[N], sf[N];
  logic [RW-1:0] srd[N];
  bit ppos = 0, pneg = 0, seen = 0, m_rise = 0, m_fall = 0, m_idle = 0, m_err = 0;
  logic [RW-1:0] m_rd = '0;
  logic [FW-1:0] m_fd = '0;
  logic [LW-1:0] m_lv = '0;
  bit p = 0, n = 0;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s at edge %0d: got %h expected %h", tag, e, got, exp);
    end
  endtask
  // Each TCK toggle seen at clk edge k must show up as a one-cycle pulse after edge k+S
  task automatic step(input bit tp, input bit tn, input logic [RW-1:0] d, input logic [FW-1:0] f,
                      input logic [LW-1:0] l, input bit c, input bit r);
    pos = tp; neg = tn; rd = d; fd = f; lv = l; clr = c; rst = r;
    @(posedge clk); #1;
    e++;
    if (r) begin
      for (int i = e; i < N; i++) begin sr[i] = 0; sf[i] = 0; end
      ppos = 0; pneg = 0; seen = 0; since = 0;
      m_rise = 0; m_fall = 0; m_idle = 0; m_err = 0; m_rd = '0; m_fd = '0; m_lv = '0;
    end else begin
      m_idle = (since >= SAT);
      m_rise = sr[e];
      m_rd   = sr[e] ? srd[e] : '0;
      m_fall = sf[e];
      m_fd   = sf[e] ? f : '0;
      if (sr[e]) m_lv = l;
`ifdef SCR1_TAPC_SYNC_RATIO_CHK_EN
      if (sr[e] && seen && since + 1 < MR) m_err = 1;
      else if (c) m_err = 0;
      if (sr[e]) seen = 1;
`endif
      since = sr[e] ? 0 : (since < SAT ? since + 1 : SAT);
      if (tp != ppos) begin sr[e+S] = 1; srd[e+S] = d; end
      if (tn != pneg) sf[e+S] = 1;
      ppos = tp; pneg = tn;
    end
    chk("tck_rise", 16'(tck_rise_o), 16'(m_rise));
    chk("rise_data", 16'(rise_data_o), 16'(m_rd));
    chk("tck_fall", 16'(tck_fall_o), 16'(m_fall));
    chk("fall_data", 16'(fall_data_o), 16'(m_fd));
    chk("level", 16'(level_o), 16'(m_lv));
    chk("idle", 16'(tck_idle_o), 16'(m_idle));
    chk("ratio_err", 16'(ratio_err_o), 16'(m_err));
  endtask
  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(p, n, '0, '0, m_lv, 0, 0);
  endtask
  initial begin
    repeat (3) step(0, 0, '0, '0, '0, 0, 1);
    while (e < 9) step(0, 0, '0, '0, '0, 0, 0);
    p = 1;
    step(p, n, 3'b101, '0, 8'hA5, 0, 0);
    step(p, n, 3'b000, '0, 8'h3C, 0, 0);
    step(p, n, 3'b000, '0, 8'h3C, 0, 0);
    chk("t1_rise", 16'(tck_rise_o), 16'd1);
    chk("t1_data", 16'(rise_data_o), 16'h5);
    chk("t1_level", 16'(level_o), 16'h3C);
    step(p, n, 3'b000, '0, 8'h3C, 0, 0);
    chk("t1_rise_end", 16'(tck_rise_o), 16'd0);
    chk("t1_data_end", 16'(rise_data_o), 16'd0);
    n = 1;
    step(p, n, '0, 1'b1, 8'h3C, 0, 0);
    step(p, n, '0, 1'b1, 8'h3C, 0, 0);
    step(p, n, '0, 1'b1, 8'h3C, 0, 0);
    chk("t2_fall", 16'(tck_fall_o), 16'd1);
    chk("t2_fdata", 16'(fall_data_o), 16'd1);
    chk("t2_rise", 16'(tck_rise_o), 16'd0);
    step(p, n, '0, 1'b1, 8'h3C, 0, 0);
    chk("t2_fall_end", 16'(tck_fall_o), 16'd0);
    for (int i = 0; i < 10; i++) begin
      p = ~p;
      step(p, n, 3'($urandom), '0, 8'($urandom), 0, 0);
      step(p, n, 3'($urandom), '0, 8'($urandom), 0, 0);
    end
    idle_steps(3);
    step(p, n, '0, '0, m_lv, 1, 0);
    idle_steps(2);
    chk("t3_err_cleared", 16'(ratio_err_o), 16'd0);
    idle_steps(25);
    chk("t4_idle", 16'(tck_idle_o), 16'd1);
    p = ~p;
    step(p, n, 3'b011, '0, 8'h77, 0, 0);
    idle_steps(S);
    chk("t4_rise", 16'(tck_rise_o), 16'd1);
    chk("t4_idle_hold", 16'(tck_idle_o), 16'd1);
    idle_steps(1);
    chk("t4_idle_drop", 16'(tck_idle_o), 16'd0);
    if (p) begin p = 0; step(p, n, '0, '0, m_lv, 0, 0); idle_steps(6); end
    p = 1;
    step(p, n, 3'b110, '0, 8'h11, 0, 0);
    idle_steps(S - 1);
    chk("t5_pending", 16'(tck_rise_o), 16'd0);
    step(p, n, '0, '0, 8'h11, 0, 1);
    chk("t5_rise_rst", 16'(tck_rise_o), 16'd0);
    chk("t5_level_rst", 16'(level_o), 16'd0);
    p = 0; n = 0;
    idle_steps(8);
    for (int i = 0; i < 100; i++) begin
      p = ~p;
      step(p, n, 3'($urandom), 1'($urandom), 8'($urandom), 0, 0);
      for (int j = 0; j < 7; j++) step(p, n, 3'($urandom), 1'($urandom), 8'($urandom), 0, 0);
    end
    chk("t6_no_err", 16'(ratio_err_o), 16'd0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(2) == 0) p = ~p;
      if ($urandom_range(2) == 0) n = ~n;
      step(p, n, 3'($urandom), 1'($urandom), 8'($urandom), $urandom_range(15) == 0,
           $urandom_range(99) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/scr1_tapc_sync_os.md
Name: scr1_tapc_sync_os

Overview:
Parametrised TCK-to-SysCLK oversampling synchronizer for the debug TAP path. It runs entirely in the system clock domain and receives TCK-domain toggle flags plus TCK-domain data. It produces TCK rise and fall strobes, a one-cycle pulse re-timing of an arbitrary number of rise- and fall-qualified channels, and held level channels. Beyond plain re-timing it adds TCK-idle detection and an optional TCK/SysCLK ratio checker. It sits between the TAP controller and the DMI/SCU logic as a generalised replacement for the fixed-width synchronizer.

Parameters:
SYNC_STAGES, 2, metastability flops per synchronizer chain (legal 2..4).
RISE_W, 3, width of the rise-qualified pulsed channel bus (capture, shift, tdi).
FALL_W, 1, width of the fall-qualified pulsed channel bus (update).
LEVEL_W, 8, width of the held level bus (chain select, chain id).
IDLE_CNT_W, 8, width of the TCK idle counter.
MIN_RATIO, 4, minimum SysCLK cycles required between successive TCK rises (ratio checker).

Ports:
clk  in  1  system clock (SysCLK)
rst  in  1  reset, synchronous, active-high
tck_divpos_i  in  1  toggles on every TCK posedge (TCK domain)
tck_divneg_i  in  1  toggles on every TCK negedge (TCK domain)
rise_data_i  in  RISE_W  pulsed channels, launched on TCK edge (TCK domain)
fall_data_i  in  FALL_W  pulsed channels, stable across TCK fall (TCK domain)
level_i  in  LEVEL_W  quasi-static level channels (TCK domain)
err_clr_i  in  1  clears ratio_err_o
tck_rise_o  out  1  one-cycle strobe per detected TCK rise
tck_fall_o  out  1  one-cycle strobe per detected TCK fall
rise_data_o  out  RISE_W  rise channels, valid only while tck_rise_o=1, else 0
fall_data_o  out  FALL_W  fall channels, valid only while tck_fall_o=1, else 0
level_o  out  LEVEL_W  level channels, held
tck_idle_o  out  1  no TCK rise for 2^IDLE_CNT_W-1 cycles
ratio_err_o  out  1  sticky ratio violation flag

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high. Every flop clears on the posedge of clk while rst=1.
- Reset values: all outputs are 0. All sync chains, the idle counter, the seen_edge flag and ratio_err_o are 0.
- Toggle chains: pos_sync and neg_sync, each SYNC_STAGES+2 flops, index 0 first.
  - rise_load = pos_sync[S]^pos_sync[S-1]; rise_rst = pos_sync[S+1]^pos_sync[S].
  - fall_load and fall_rst are formed the same way from neg_sync.
- Rise data: rise_data_i passes through an S-flop chain, tapped at [S-1].
- Output register update, each cycle:
  - If rise_load: rise_data_o <= tap and tck_rise_o <= 1.
  - Else if rise_rst: rise_data_o <= 0 and tck_rise_o <= 0.
  - Load has priority over reset when back-to-back edges coincide.
- Fall channels: fall_data_o <= fall_data_i on fall_load. It clears on fall_rst with the same priority rule. tck_fall_o is the registered fall_load.
- Level channels: level_o <= level_i on rise_load only. They are never cleared except by rst.
- Latency: a toggle captured into pos_sync[0] at clk edge k gives outputs valid after edge k+S, for exactly one cycle.
- Idle counter:
  - Resets to 0 on rise_load.
  - Otherwise increments and saturates at all-ones.
  - tck_idle_o = (counter == all-ones), registered, so it deasserts the cycle after the first rise_load.
- Reset and first-edge conditions:
  - rst mid-transfer drops any pending pulse immediately.
  - If a toggle input is 1 while rst releases, exactly one spurious rise or fall pulse may follow. This is accepted; the TAP holds trst during system reset.
- No pulse is ever stretched or duplicated. Edges closer than 1 clk are aliased, and detecting that is the ratio checker's job.

Optional Feature:
Macro: SCR1_TAPC_SYNC_RATIO_CHK_EN.
- With the macro:
  - On rise_load with seen_edge=1 and idle counter < MIN_RATIO-1, ratio_err_o <= 1 (sticky).
  - seen_edge is set on the first rise_load.
  - err_clr_i clears ratio_err_o; a simultaneous set wins.
- Without the macro: ratio_err_o is tied 0, err_clr_i is ignored, and seen_edge and the comparator are absent.

Test Plan:
1. Reset, then S=2, toggle tck_divpos_i at clk edge 10 with rise_data_i=3'b101 → tck_rise_o=1 and rise_data_o=3'b101 in cycle after edge 12 only, 0 after edge 13. level_o is updated the same cycle.
2. Toggle tck_divneg_i with fall_data_i=1 → tck_fall_o and fall_data_o are 1 for one cycle, 2 cycles after capture. Rise outputs stay 0.
3. Rise toggles every 2 clk → every toggle yields a separate 1-cycle pulse with no merge. With the macro and MIN_RATIO=4, ratio_err_o=1 after the second rise; err_clr_i pulse → 0 next cycle.
4. IDLE_CNT_W=4, no TCK activity → tck_idle_o=1 at cycle 15 after last rise. One rise → tck_idle_o=0 the following cycle.
5. Assert rst the cycle tck_rise_o=1 → all outputs 0 next edge. No pulse reappears after release with toggles held.
6. Rise toggles every 8 clk, MIN_RATIO=4 → ratio_err_o stays 0 for 100 edges, and all pulses equal the driven data.
